// File: rtl/serial_link_bringup_seq.sv
`timescale 1ns/1ps
// Serial link bring-up sequencer: walks each enabled link through reset, allocator setup, settle, de-isolation and isolation polling.
// Defining SERIAL_LINK_BRINGUP_PERF_EN adds perf_cycles_o, a saturating count of busy cycles.
module serial_link_bringup_seq #(
    parameter int NumLinks = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter logic [AddrWidth-1:0] CtrlOffset = 'h0,
    parameter logic [AddrWidth-1:0] AllocTxOffset = 'h10,
    parameter logic [AddrWidth-1:0] AllocRxOffset = 'h14,
    parameter logic [AddrWidth-1:0] IsolatedOffset = 'h18,
    parameter logic [DataWidth-1:0] AllocCfg = 'h3,
    parameter int SettleCycles = 50,
    parameter int PollMax = 1024
) (
    input  logic                          clk_1,
    input  logic                          rst_1_n,
    input  logic                          start_i,
    input  logic [NumLinks-1:0]           link_mask_i,
    output logic                          reg_valid_o,
    input  logic                          reg_ready_i,
    output logic                          reg_write_o,
    output logic [AddrWidth-1:0]          reg_addr_o,
    output logic [DataWidth-1:0]          reg_wdata_o,
    output logic [DataWidth/8-1:0]        reg_wstrb_o,
    input  logic [DataWidth-1:0]          reg_rdata_i,
    input  logic                          reg_error_i,
    output logic [NumLinks-1:0]           reg_sel_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [((NumLinks > 1) ? $clog2(NumLinks) : 1)-1:0] err_link_o,
    output logic [NumLinks-1:0]           link_ready_o
`ifdef SERIAL_LINK_BRINGUP_PERF_EN
    ,
    output logic [31:0]                   perf_cycles_o
`endif
);
    localparam int IdxW = (NumLinks > 1) ? $clog2(NumLinks) : 1;
    localparam int SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam int PollW = $clog2(PollMax + 1);

    localparam logic [DataWidth-1:0] CtrlRstDea = DataWidth'(32'h300);
    localparam logic [DataWidth-1:0] CtrlRstA   = DataWidth'(32'h302);
    localparam logic [DataWidth-1:0] CtrlClkEn  = DataWidth'(32'h303);
    localparam logic [DataWidth-1:0] CtrlDeIso  = DataWidth'(32'h003);

    // IDLE/DONE/ERROR accept start; W_* issue one write, R_ISO repeats reads back-to-back;
    // SETTLE is a bus-quiet down-count; SEL picks the next enabled link, NEXT retires the current one.
    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_W_RSTDEA, S_W_RSTA, S_W_CLKEN, S_W_ATX, S_W_ARX,
        S_SETTLE, S_W_DEISO, S_R_ISO, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d, sel_idx;
    logic [NumLinks-1:0] mask_q, mask_d;
    logic [NumLinks-1:0] ready_q, ready_d;
    logic [SetW-1:0]     settle_q, settle_d;
    logic [PollW-1:0]    poll_q, poll_d;
    logic                sel_found;
    logic                hs;
    logic                start_ok;
    logic                unused_rdata;

    assign unused_rdata = ^reg_rdata_i[DataWidth-1:2];
    assign hs = reg_valid_o & reg_ready_i;
    assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = idx_q;
        for (int i = NumLinks - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    always_comb begin
        reg_valid_o = 1'b0;
        reg_write_o = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        case (state_q)
            S_W_RSTDEA: begin reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_addr_o = CtrlOffset;    reg_wdata_o = CtrlRstDea; end
            S_W_RSTA:   begin reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_addr_o = CtrlOffset;    reg_wdata_o = CtrlRstA;   end
            S_W_CLKEN:  begin reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_addr_o = CtrlOffset;    reg_wdata_o = CtrlClkEn;  end
            S_W_ATX:    begin reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_addr_o = AllocTxOffset; reg_wdata_o = AllocCfg;   end
            S_W_ARX:    begin reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_addr_o = AllocRxOffset; reg_wdata_o = AllocCfg;   end
            S_W_DEISO:  begin reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_addr_o = CtrlOffset;    reg_wdata_o = CtrlDeIso;  end
            S_R_ISO:    begin reg_valid_o = 1'b1; reg_addr_o = IsolatedOffset; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        ready_d  = ready_q;
        settle_d = settle_q;
        poll_d   = poll_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_SEL;
                    idx_d   = '0;
                    mask_d  = link_mask_i;
                    ready_d = '0;
                    poll_d  = '0;
                end
            end
            S_SEL: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    state_d = S_W_RSTDEA;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_W_RSTDEA: if (hs) state_d = reg_error_i ? S_ERROR : S_W_RSTA;
            S_W_RSTA:   if (hs) state_d = reg_error_i ? S_ERROR : S_W_CLKEN;
            S_W_CLKEN:  if (hs) state_d = reg_error_i ? S_ERROR : S_W_ATX;
            S_W_ATX:    if (hs) state_d = reg_error_i ? S_ERROR : S_W_ARX;
            S_W_ARX: begin
                if (hs) begin
                    if (reg_error_i) begin
                        state_d = S_ERROR;
                    end else if (SettleCycles == 0) begin
                        state_d = S_W_DEISO;
                    end else begin
                        settle_d = SetW'(SettleCycles - 1);
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d = S_W_DEISO;
                else                settle_d = settle_q - 1'b1;
            end
            S_W_DEISO: if (hs) state_d = reg_error_i ? S_ERROR : S_R_ISO;
            S_R_ISO: begin
                if (hs) begin
                    poll_d = poll_q + 1'b1;
                    if (reg_error_i) begin
                        state_d = S_ERROR;
                    end else if (reg_rdata_i[1:0] == 2'b00) begin
                        ready_d[idx_q] = 1'b1;
                        state_d        = S_NEXT;
                    end else if (poll_d == PollW'(PollMax)) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_NEXT: begin
                poll_d = '0;
                if (idx_q == IdxW'(NumLinks - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SEL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            mask_q   <= '0;
            ready_q  <= '0;
            settle_q <= '0;
            poll_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            ready_q  <= ready_d;
            settle_q <= settle_d;
            poll_q   <= poll_d;
        end
    end

    assign busy_o       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERROR);
    assign err_link_o   = error_o ? idx_q : '0;
    assign link_ready_o = ready_q;
    assign reg_wstrb_o  = '1;
    assign reg_sel_o    = reg_valid_o ? (NumLinks'(1) << idx_q) : '0;

`ifdef SERIAL_LINK_BRINGUP_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n)                        perf_q <= '0;
        else if (start_ok)                  perf_q <= '0;
        else if (busy_o && (perf_q != '1))  perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles_o = perf_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_serial_link_bringup_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for serial_link_bringup_seq: a reference model predicts every bus request and final flag,
// a randomized register-bus slave responds, and a monitor pops predictions on each handshake.
module tb_serial_link_bringup_seq;
    localparam int NL = 2;
    localparam int SETTLE = 50;
    localparam int PMAX = 8;
    localparam logic [31:0] CTRL = 32'h0;
    localparam logic [31:0] ATX  = 32'h10;
    localparam logic [31:0] ARX  = 32'h14;
    localparam logic [31:0] ISO  = 32'h18;
    localparam logic [31:0] ACFG = 32'h3;

    logic        clk_1 = 1'b0;
    logic        rst_1_n;
    logic        start_i;
    logic [1:0]  link_mask_i;
    logic        reg_valid_o, reg_ready_i, reg_write_o, reg_error_i;
    logic [31:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
    logic [3:0]  reg_wstrb_o;
    logic [1:0]  reg_sel_o, link_ready_o;
    logic        busy_o, done_o, error_o;
    logic [0:0]  err_link_o;
`ifdef SERIAL_LINK_BRINGUP_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    serial_link_bringup_seq #(
        .NumLinks(NL), .AddrWidth(32), .DataWidth(32),
        .CtrlOffset(CTRL), .AllocTxOffset(ATX), .AllocRxOffset(ARX), .IsolatedOffset(ISO),
        .AllocCfg(ACFG), .SettleCycles(SETTLE), .PollMax(PMAX)
    ) dut (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .start_i(start_i), .link_mask_i(link_mask_i),
        .reg_valid_o(reg_valid_o), .reg_ready_i(reg_ready_i), .reg_write_o(reg_write_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
        .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i), .reg_sel_o(reg_sel_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_link_o(err_link_o),
        .link_ready_o(link_ready_o)
`ifdef SERIAL_LINK_BRINGUP_PERF_EN
        , .perf_cycles_o(perf_cycles_o)
`endif
    );

    always #5 clk_1 = ~clk_1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sel;
        int          idle;
    } req_t;

    req_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    int   bp_max = 0;
    int   busy_reads[NL];
    int   reads_done[NL];
    int   err_link = -1;
    int   err_step = -1;
    int   wait_left = 0;
    bit   hs_pending = 0;
    bit   hs_read = 0;
    int   hs_link = 0;

    bit   exp_done, exp_err;
    int   exp_err_link;
    logic [1:0] exp_ready;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int step_of(input logic wr, input logic [31:0] a, input logic [31:0] d, input int rdone);
        if (!wr) return (rdone == 0) ? 6 : -1;
        if (a == ATX) return 3;
        if (a == ARX) return 4;
        case (d)
            32'h300: return 0;
            32'h302: return 1;
            32'h303: return 2;
            32'h003: return 5;
            default: return -1;
        endcase
    endfunction

    // Reference model: the request list each enabled link should see and the final flags.
    task automatic build_expected(input logic [1:0] mask);
        logic [31:0] wa[6];
        logic [31:0] wd[6];
        logic [1:0]  s;
        req_t        r;
        wa = '{CTRL, CTRL, CTRL, ATX, ARX, CTRL};
        wd = '{32'h300, 32'h302, 32'h303, ACFG, ACFG, 32'h003};
        exp_done = 0; exp_err = 0; exp_err_link = 0; exp_ready = 2'b00;
        for (int l = 0; l < NL; l++) begin
            if (!mask[l]) continue;
            s = (l == 0) ? 2'b01 : 2'b10;
            for (int st = 0; st < 6; st++) begin
                r.wr = 1; r.addr = wa[st]; r.wdata = wd[st]; r.sel = s;
                r.idle = (st == 0) ? -1 : ((st == 5) ? SETTLE : 0);
                exp_q.push_back(r);
                if (l == err_link && st == err_step) begin
                    exp_err = 1; exp_err_link = l; return;
                end
            end
            for (int k = 0; k < PMAX; k++) begin
                r.wr = 0; r.addr = ISO; r.wdata = 0; r.sel = s; r.idle = 0;
                exp_q.push_back(r);
                if (k == 0 && l == err_link && err_step == 6) begin
                    exp_err = 1; exp_err_link = l; return;
                end
                if (k >= busy_reads[l]) begin
                    exp_ready[l] = 1'b1;
                    break;
                end
                if (k + 1 >= PMAX) begin
                    exp_err = 1; exp_err_link = l; return;
                end
            end
        end
        exp_done = 1;
    endtask

    // Register-bus slave with random backpressure and scripted ISOLATED / error responses.
    initial begin
        logic [31:0] rd;
        int          l;
        reg_ready_i = 0; reg_error_i = 0; reg_rdata_i = 0;
        forever begin
            @(negedge clk_1);
            if (rst_1_n) begin
                reg_ready_i = 0; reg_error_i = 0; hs_pending = 0;
                continue;
            end
            if (hs_pending) begin
                if (hs_read) reads_done[hs_link]++;
                wait_left = $urandom_range(0, bp_max);
                hs_pending = 0;
            end
            reg_ready_i = 0; reg_error_i = 0; reg_rdata_i = $urandom;
            if (reg_valid_o) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    l = reg_sel_o[1] ? 1 : 0;
                    rd = $urandom;
                    rd[1:0] = (reads_done[l] < busy_reads[l]) ? 2'($urandom_range(1, 3)) : 2'b00;
                    reg_rdata_i = rd;
                    reg_ready_i = 1;
                    reg_error_i = (l == err_link) &&
                                  (step_of(reg_write_o, reg_addr_o, reg_wdata_o, reads_done[l]) == err_step);
                    hs_pending = 1; hs_read = !reg_write_o; hs_link = l;
                end
            end
        end
    end

    // Monitor: pops a prediction on every handshake; also checks request stability under backpressure.
    initial begin
        req_t        r;
        bit          stall_prev;
        int          idle;
        logic        p_wr;
        logic [31:0] p_addr, p_wdata;
        logic [1:0]  p_sel;
        stall_prev = 0; idle = 0; p_wr = 0; p_addr = 0; p_wdata = 0; p_sel = 0;
        forever begin
            @(negedge clk_1);
            #1;
            if (rst_1_n) begin
                stall_prev = 0; idle = 0;
                continue;
            end
            if (stall_prev) begin
                tests++;
                if (!reg_valid_o || reg_write_o !== p_wr || reg_addr_o !== p_addr ||
                    reg_wdata_o !== p_wdata || reg_sel_o !== p_sel) begin
                    fails++;
                    $display("FAIL req_stable: valid %0b wr %0b addr %h wdata %h sel %b, held wr %0b addr %h wdata %h sel %b",
                             reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_sel_o, p_wr, p_addr, p_wdata, p_sel);
                end
            end
            stall_prev = reg_valid_o && !reg_ready_i;
            if (stall_prev) begin
                p_wr = reg_write_o; p_addr = reg_addr_o; p_wdata = reg_wdata_o; p_sel = reg_sel_o;
            end
            if (reg_valid_o && reg_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: wr %0b addr %h wdata %h sel %b, expected no request",
                             reg_write_o, reg_addr_o, reg_wdata_o, reg_sel_o);
                end else begin
                    r = exp_q.pop_front();
                    check("req_write", int'(reg_write_o), int'(r.wr));
                    check("req_addr", int'(reg_addr_o), int'(r.addr));
                    if (r.wr) check("req_wdata", int'(reg_wdata_o), int'(r.wdata));
                    check("req_sel", int'(reg_sel_o), int'(r.sel));
                    check("req_wstrb", int'(reg_wstrb_o), 15);
                    if (r.idle >= 0) check("req_gap", idle, r.idle);
                end
                idle = 0;
            end else if (!reg_valid_o) begin
                idle++;
            end
        end
    end

    task automatic run(input logic [1:0] mask, input int bp, input int b0, input int b1,
                       input int el, input int es, input bit poke);
        int busy_cnt, done_cyc;
        bit fin;
        bp_max = bp; busy_reads[0] = b0; busy_reads[1] = b1;
        reads_done[0] = 0; reads_done[1] = 0;
        err_link = el; err_step = es;
        wait_left = $urandom_range(0, bp);
        exp_q.delete();
        build_expected(mask);
        @(negedge clk_1);
        start_i = 1; link_mask_i = mask;
        busy_cnt = 0; fin = 0; done_cyc = -1;
        for (int cyc = 1; cyc < 20000 && !fin; cyc++) begin
            @(negedge clk_1);
            start_i = (poke && cyc == 30) ? 1'b1 : 1'b0;
            link_mask_i = 2'($urandom);
            if (cyc == 1) begin
                check("start_clears_done", int'(done_o), 0);
                check("start_clears_error", int'(error_o), 0);
                check("start_clears_ready", int'(link_ready_o), 0);
            end
            if (busy_o) busy_cnt++;
            if (done_o || error_o) begin
                fin = 1; done_cyc = cyc;
            end
        end
        start_i = 0;
        if (!fin) begin
            tests++; fails++;
            $display("FAIL run_timeout: no done/error within 20000 cycles, mask %b", mask);
        end
        repeat (5) @(negedge clk_1);
        #1;
        check("no_req_after_end", int'(reg_valid_o), 0);
        check("queue_drained", exp_q.size(), 0);
        check("done_o", int'(done_o), int'(exp_done));
        check("error_o", int'(error_o), int'(exp_err));
        if (exp_err) check("err_link_o", int'(err_link_o), exp_err_link);
        check("link_ready_o", int'(link_ready_o), int'(exp_ready));
        check("busy_o_end", int'(busy_o), 0);
        check("sel_idle", int'(reg_sel_o), 0);
        if (mask == 2'b00) check("zero_mask_done_latency", done_cyc, 2);
`ifdef SERIAL_LINK_BRINGUP_PERF_EN
        check("perf_cycles", int'(perf_cycles_o), busy_cnt);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(reg_valid_o), 0);
        check({tag, "_sel"}, int'(reg_sel_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_error"}, int'(error_o), 0);
        check({tag, "_err_link"}, int'(err_link_o), 0);
        check({tag, "_ready"}, int'(link_ready_o), 0);
`ifdef SERIAL_LINK_BRINGUP_PERF_EN
        check({tag, "_perf"}, int'(perf_cycles_o), 0);
`endif
    endtask

    task automatic reset_mid_settle();
        bp_max = 0; busy_reads[0] = 0; busy_reads[1] = 0;
        reads_done[0] = 0; reads_done[1] = 0;
        err_link = -1; err_step = -1; wait_left = 0;
        exp_q.delete();
        build_expected(2'b11);
        @(negedge clk_1);
        start_i = 1; link_mask_i = 2'b11;
        @(negedge clk_1);
        start_i = 0;
        repeat (14) @(negedge clk_1);
        #1;
        check("settle_busy", int'(busy_o), 1);
        check("settle_quiet", int'(reg_valid_o), 0);
        #1;
        rst_1_n = 1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(negedge clk_1);
        rst_1_n = 0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, bp, b0, b1, el, es;
        start_i = 0; link_mask_i = 0; rst_1_n = 1;
        repeat (3) @(negedge clk_1);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_1);
        rst_1_n = 0;

        run(2'b11, 0, 0, 0, -1, -1, 0);
        run(2'b10, 0, 0, 0, -1, -1, 0);
        run(2'b00, 0, 0, 0, -1, -1, 0);
        run(2'b11, 5, 3, 3, -1, -1, 0);
        run(2'b11, 3, 0, 1000, -1, -1, 0);
        run(2'b11, 2, 1, 1, 0, 2, 0);
        run(2'b11, 2, 0, 2, -1, -1, 1);
        reset_mid_settle();
        run(2'b01, 1, 2, 0, -1, -1, 0);
        for (int i = 0; i < 8; i++) begin
            m  = $urandom_range(0, 3);
            bp = $urandom_range(0, 5);
            b0 = $urandom_range(0, 9);
            b1 = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                el = $urandom_range(0, 1);
                es = $urandom_range(0, 6);
            end else begin
                el = -1; es = -1;
            end
            run(2'(m), bp, b0, b1, el, es, i[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_link_bringup_seq.md
Name: serial_link_bringup_seq

Overview:
Hardware sequencer that brings up one or more serial links through their register-bus config ports, replacing software-driven start-up. On start, it walks each enabled link in index order through a fixed sequence:
- reset/clock-gate writes;
- channel-allocator configuration;
- settle wait;
- AXI de-isolation;
- polling of the isolation status until clear.

It sits between the SoC control logic and the per-link cfg ports (external demux on reg_sel_o) and reports per-link readiness or failure.

Parameters:
NumLinks, 2, number of links sequenced (≥1)
AddrWidth, 32, reg-bus address width
DataWidth, 32, reg-bus data width (≥32)
CtrlOffset, 32'h0, address of link CTRL register
AllocTxOffset, 32'h??, address of CHANNEL_ALLOC_TX_CFG (set per integration)
AllocRxOffset, 32'h??, address of CHANNEL_ALLOC_RX_CFG (set per integration)
IsolatedOffset, 32'h??, address of ISOLATED status register
AllocCfg, 32'h3, value written to both allocator cfg registers (bypass + auto-flush)
SettleCycles, 50, wait cycles between allocator config and de-isolation
PollMax, 1024, maximum ISOLATED reads per link before timeout

Ports:
clk_1  in  1  clock
rst_1_n  in  1  reset, asynchronous, active-high
start_i  in  1  pulse: begin bring-up (sampled in IDLE/DONE/ERROR only)
link_mask_i  in  NumLinks  1 = link included; sampled at start
reg_valid_o  out  1  reg request valid
reg_ready_i  in  1  reg request accepted/response valid
reg_write_o  out  1  1 = write, 0 = read
reg_addr_o  out  AddrWidth  request address
reg_wdata_o  out  DataWidth  write data
reg_wstrb_o  out  DataWidth/8  write strobe (always all-ones)
reg_rdata_i  in  DataWidth  read data, valid with reg_ready_i
reg_error_i  in  1  bus error, valid with reg_ready_i
reg_sel_o  out  NumLinks  one-hot target link (0 when idle)
busy_o  out  1  sequence in progress
done_o  out  1  all enabled links ready (sticky until next start)
error_o  out  1  sequence aborted (sticky until next start)
err_link_o  out  $clog2(NumLinks) (min 1)  index of failing link
link_ready_o  out  NumLinks  per-link ready flags

Behaviour:
- Reset: all outputs 0, FSM IDLE, link index 0, counters 0.
- Reg handshake:
  - reg_valid_o is asserted with addr/wdata/write/sel stable until reg_valid_o & reg_ready_i.
  - Exactly one request is outstanding at a time.
  - reg_valid_o is never dropped without a handshake, except on reset.
- FSM states: IDLE → SEL → W_RSTDEA(Ctrl=0x300) → W_RSTA(Ctrl=0x302) → W_CLKEN(Ctrl=0x303) → W_ATX(AllocTx=AllocCfg) → W_ARX(AllocRx=AllocCfg) → SETTLE → W_DEISO(Ctrl=0x03) → R_ISO → NEXT → DONE/ERROR.
- Start: start_i in IDLE/DONE/ERROR clears done_o, error_o and link_ready_o, latches the mask, sets busy_o next cycle, and enters SEL. start_i while busy is ignored.
- SEL: advance the index to the lowest enabled link ≥ current index. If none remain, go to DONE. An all-zero mask gives done_o=1 two cycles after start.
- Write states: on handshake, go to the next state. If reg_error_i=1, go to ERROR.
- SETTLE: counts SettleCycles cycles with reg_valid_o=0. SettleCycles=0 skips the state.
- R_ISO: each completed read increments the poll counter.
  - Read with error → ERROR.
  - rdata[1:0]==0 → set link_ready_o[idx], go to NEXT.
  - Otherwise, poll counter reaching PollMax → ERROR; else issue another read, with no gap cycle.
- NEXT: idx+1, clear the poll counter. If idx==NumLinks-1, go to DONE; else go to SEL.
- DONE: busy_o=0, done_o=1.
- ERROR: busy_o=0, error_o=1, err_link_o=idx. link_ready_o keeps the flags of earlier links. No further bus requests are issued.
- Asynchronous reset mid-sequence: immediate return to reset state. Any in-flight request is dropped.

Optional Feature:
SERIAL_LINK_BRINGUP_PERF_EN:
- Defined: adds output perf_cycles_o (32 bits), reset 0. It is cleared on accepted start and increments every cycle while busy_o=1, saturating at 32'hFFFFFFFF. It holds its value in DONE/ERROR.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- NumLinks=2, mask=2'b11, ready always 1, ISOLATED reads 0 → write order per link is 0x300, 0x302, 0x303, 3, 3, then 50 idle cycles, then 0x03 and 1 read; link_ready_o=2'b11, done_o=1, error_o=0.
- mask=2'b10 → no request has reg_sel_o=2'b01; link_ready_o=2'b10; mask=2'b00 → done_o=1 with zero requests.
- ISOLATED returns 2'b11 for 3 reads, then 0; random ready backpressure 0–5 cycles → exactly 4 reads; request fields stable while valid&!ready.
- PollMax=8, ISOLATED stuck at 1 on link 1 → 8 reads, error_o=1, err_link_o=1, link_ready_o=2'b01.
- reg_error_i=1 on the W_CLKEN write of link 0 → error_o=1, err_link_o=0, no further valid; start_i re-issued → flags cleared and full sequence completes.
- rst_1_n asserted during SETTLE → all outputs 0 immediately. start_i during busy is ignored. With SERIAL_LINK_BRINGUP_PERF_EN defined, perf_cycles_o equals the measured busy duration.
